con_ex_pipe: RTL and testbench
==============================

# con_ex_pipe

Parametrised execute stage with a valid/ready handshake on both sides, stall and flush support, and an iterative unsigned multiply/divide unit. Sits between decode and memory in the core pipeline. Replaces the free-running ID/EX latch plus ALU pairing:
- holds one instruction at a time;
- back-pressures decode while a multi-cycle op runs or memory stalls;
- discards its contents on a branch/exception flush.

## Interface
- WordSize, 32, datapath width (≥8, power of two)
- MdEnable, 1, 1 = multiply/divide unit present; 0 = MD modes treated as ALU ops
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard held/in-flight instruction
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept this cycle
- branch_taken_in  in  1  forwarded to branch_taken
- a_sel  in  2  A operand: 0 rs1d, 1 pc_in, 2 zero, 3 rs1d
- b_sel  in  2  B operand: 0 rs2d_in, 1 imm, 2 constant 4, 3 zero
- imm, pc_in, rs1d, rs2d_in, branch_addr_in  in  WordSize  decode payload
- rdn_in  in  5  destination register
- alu_mode  in  6  operation; MD codes from ex_pkg
- out_valid  out  1  result presented to memory stage
- out_ready  in  1  memory stage consumes result
- branch_taken  out  1  latched sideband
- rdn  out  5  latched sideband
- pc, branch_addr, rs2d  out  WordSize  latched sideband
- alu_out  out  WordSize  result

## Operation
- Three states:
  - EMPTY: nothing held.
  - BUSY: MD iterating.
  - FULL: result valid.
- Accept = in_valid && in_ready. On accept: latch muxed A/B, alu_mode and all sidebands.
  - Non-MD mode (or MdEnable=0): next state FULL.
  - MD mode: next state BUSY, iteration counter loaded with WordSize.
- in_ready = (EMPTY) || (FULL && out_ready). Combinational; never asserted in BUSY or during rst.
- out_valid = FULL.
- FULL && out_ready && !accept → EMPTY. FULL && out_ready && accept → new instruction loaded (back-to-back, no bubble).
- BUSY: one iteration per cycle; counter decrements; at counter==1 the result is registered and the state goes to FULL.
- MD ops are unsigned only: MUL (low word), MULHU (high word), DIVU, REMU.
  - Multiply: shift-add, 2·WordSize product.
  - Divide: restoring.
  - Divide by zero: DIVU → all ones, REMU → dividend. Still takes full latency.
- Non-MD result: existing Alu driven from the latched A/B/mode; alu_out is combinational from the registers while FULL.
- MD result: registered in muldiv_iter; alu_out muxes it while FULL.
- flush: next state EMPTY, MD aborted, counter cleared. flush beats accept in the same cycle: in_ready may be 1, but no instruction is taken. Sidebands may hold stale values; consumers qualify with out_valid.
- Reset: state EMPTY; all outputs 0; counter 0.

## Timing
- ALU ops: accepted at edge N → out_valid from edge N (visible cycle N+1), i.e. 1-cycle latency.
- MD ops: accepted at edge N → out_valid after edge N+WordSize.
- Throughput: 1 ALU op/cycle with out_ready held high; MD occupies the stage WordSize+1 cycles.
- out_valid deasserted while out_ready=0 holds all outputs stable.
- rst asserted mid-BUSY: immediate return to EMPTY, outputs 0, no partial result emitted.

## Structure
- ex_pkg holds:
  - alu_mode constants, including MD_MUL, MD_MULHU, MD_DIVU, MD_REMU;
  - an is_md(mode) function;
  - the a_sel/b_sel encodings;
  - the state enum {EMPTY, BUSY, FULL}.
- One sub-module: muldiv_iter (start, op, a, b, busy, done, result); counter width $clog2(WordSize)+1.
- Existing Alu instantiated unchanged.

## Test plan
- ADD, a_sel=0, b_sel=1, rs1d=5, imm=7, out_ready=1 → alu_out=12, out_valid for one cycle, rdn/pc passed through. Back-to-back second op accepted next cycle with no bubble.
- MUL 0xFFFF_FFFF×2, WordSize=32:
  - in_ready=0 for 32 cycles;
  - then alu_out=0xFFFF_FFFE;
  - MULHU same operands → 0x0000_0001.
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 → 0xFFFF_FFFF, REMU 9/0 → 9.
- FULL with out_ready=0 for 5 cycles → outputs frozen, in_ready=0; raising out_ready with in_valid=1 swaps to the new instruction in one edge.
- flush at BUSY cycle 10 → EMPTY next cycle, no out_valid. flush together with in_valid → instruction not taken.
- rst pulse mid-BUSY → all outputs 0, out_valid=0; in_ready=1 the first cycle after rst drops.

Source files
------------

// File: rtl/con_ex_pipe_pkg.sv
// Shared definitions for the execute stage.
// Contents:
//   - ALU operation codes, including the multiply/divide codes MD_*
//   - is_md(): tells whether an operation code belongs to the multiply/divide unit
//   - a_sel / b_sel operand-select encodings
//   - stage state enum and the internal multiply/divide op enum
package con_ex_pipe_pkg;

  localparam logic [5:0] ALU_ADD    = 6'h00;
  localparam logic [5:0] ALU_SUB    = 6'h01;
  localparam logic [5:0] ALU_AND    = 6'h02;
  localparam logic [5:0] ALU_OR     = 6'h03;
  localparam logic [5:0] ALU_XOR    = 6'h04;
  localparam logic [5:0] ALU_SLL    = 6'h05;
  localparam logic [5:0] ALU_SRL    = 6'h06;
  localparam logic [5:0] ALU_SRA    = 6'h07;
  localparam logic [5:0] ALU_SLT    = 6'h08;
  localparam logic [5:0] ALU_SLTU   = 6'h09;
  localparam logic [5:0] ALU_PASS_B = 6'h0A;

  // The low two bits of each MD code are the md_op_t value below.
  localparam logic [5:0] MD_MUL   = 6'h20;
  localparam logic [5:0] MD_MULHU = 6'h21;
  localparam logic [5:0] MD_DIVU  = 6'h22;
  localparam logic [5:0] MD_REMU  = 6'h23;

  localparam logic [1:0] A_RS1     = 2'd0;
  localparam logic [1:0] A_PC      = 2'd1;
  localparam logic [1:0] A_ZERO    = 2'd2;
  localparam logic [1:0] A_RS1_ALT = 2'd3;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd3;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  // bit 1 = divide family, bit 0 = take the high/remainder half
  typedef enum logic [1:0] {MD_OP_MUL, MD_OP_MULHU, MD_OP_DIVU, MD_OP_REMU} md_op_t;

  function automatic logic is_md(input logic [5:0] mode);
    return (mode[5:2] == 4'b1000);
  endfunction

endpackage

// File: rtl/con_ex_pipe_if.sv
// Decode-side and memory-side signals of the execute stage.
// Modports:
//   - slave:  the execute stage itself
//   - master: its environment (decode and memory)
// Decode side: flush, in_valid/in_ready, operand selects, payload, rdn_in, alu_mode.
// Memory side: out_valid/out_ready, result alu_out and the latched sidebands.
interface con_ex_pipe_if #(parameter int WordSize = 32);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic                branch_taken_in;
  logic [1:0]          a_sel;
  logic [1:0]          b_sel;
  logic [WordSize-1:0] imm;
  logic [WordSize-1:0] pc_in;
  logic [WordSize-1:0] rs1d;
  logic [WordSize-1:0] rs2d_in;
  logic [WordSize-1:0] branch_addr_in;
  logic [4:0]          rdn_in;
  logic [5:0]          alu_mode;

  logic                out_valid;
  logic                out_ready;
  logic                branch_taken;
  logic [4:0]          rdn;
  logic [WordSize-1:0] pc;
  logic [WordSize-1:0] branch_addr;
  logic [WordSize-1:0] rs2d;
  logic [WordSize-1:0] alu_out;

  modport slave (
    input  flush, in_valid, branch_taken_in, a_sel, b_sel, imm, pc_in, rs1d,
           rs2d_in, branch_addr_in, rdn_in, alu_mode, out_ready,
    output in_ready, out_valid, branch_taken, rdn, pc, branch_addr, rs2d, alu_out
  );

  modport master (
    output flush, in_valid, branch_taken_in, a_sel, b_sel, imm, pc_in, rs1d,
           rs2d_in, branch_addr_in, rdn_in, alu_mode, out_ready,
    input  in_ready, out_valid, branch_taken, rdn, pc, branch_addr, rs2d, alu_out
  );
endinterface

// File: rtl/con_ex_pipe_alu.sv
// Existing combinational ALU used by the execute stage.
// Ports:
//   - a, b:   operands
//   - mode:   operation code
//   - result: result
// Codes it does not recognise, including the MD codes, produce 0.
module Alu
  import con_ex_pipe_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [5:0]          mode,
  output logic [WordSize-1:0] result
);
  localparam int ShW = $clog2(WordSize);

  logic [ShW-1:0] shamt;
  assign shamt = b[ShW-1:0];

  always_comb begin
    result = '0;
    case (mode)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $signed(a) >>> shamt;
      ALU_SLT:    result = {{(WordSize-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(WordSize-1){1'b0}}, (a < b)};
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end
endmodule

// File: rtl/con_ex_pipe_muldiv_iter.sv
// Iterative unsigned multiply/divide unit. Each op takes WordSize cycles.
// Ports:
//   - clk, rst: clock and asynchronous active-high reset
//   - abort:    drop any op in progress
//   - start:    load op/a/b and begin
//   - busy:     an op is iterating
//   - done:     final iteration this cycle; result updates at the edge
//   - result:   last registered result
// Multiply is shift-add on a {hi,lo} pair (lo holds the multiplier).
// Divide is restoring: hi is the partial remainder and lo shifts the dividend
// out while the quotient shifts in. A zero divisor naturally yields an
// all-ones quotient and a remainder equal to the dividend.
module muldiv_iter
  import con_ex_pipe_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                start,
  input  md_op_t              op,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [WordSize-1:0] result
);
  localparam int CntW = $clog2(WordSize) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WordSize);

  logic [CntW-1:0]     cnt_reg;
  logic [WordSize-1:0] hi_reg, lo_reg, opnd_reg, result_reg;
  logic [1:0]          op_reg;

  logic [WordSize:0]   mul_sum, div_shift, div_diff;
  logic [WordSize-1:0] hi_next, lo_next;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[WordSize-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    if (op_reg[1]) begin
      // Borrow out of the trial subtraction means "restore".
      hi_next = div_diff[WordSize] ? div_shift[WordSize-1:0] : div_diff[WordSize-1:0];
      lo_next = {lo_reg[WordSize-2:0], ~div_diff[WordSize]};
    end else begin
      hi_next = mul_sum[WordSize:1];
      lo_next = {mul_sum[0], lo_reg[WordSize-1:1]};
    end
  end

  assign busy   = (cnt_reg != '0);
  assign done   = (cnt_reg == CntW'(1));
  assign result = result_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      op_reg     <= '0;
      result_reg <= '0;
    end else if (abort) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg  <= CntLoad;
      hi_reg   <= '0;
      op_reg   <= op;
      lo_reg   <= op[1] ? a : b;
      opnd_reg <= op[1] ? b : a;
    end else if (busy) begin
      cnt_reg <= cnt_reg - CntW'(1);
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      if (done) begin
        result_reg <= op_reg[0] ? hi_next : lo_next;
      end
    end
  end
endmodule

// File: rtl/con_ex_pipe.sv
// Execute stage between decode and memory. It holds one instruction at a time.
// Ports:
//   - clk, rst: clock and asynchronous active-high reset
//   - bus:      slave modport of con_ex_pipe_if (decode and memory handshakes)
// Behaviour:
//   - ALU ops produce a result one cycle after accept.
//   - MD ops occupy the stage for WordSize cycles in BUSY, then move to FULL.
//   - flush empties the stage and has priority over an accept in the same cycle.
module con_ex_pipe
  import con_ex_pipe_pkg::*;
#(
  parameter int WordSize = 32,
  parameter bit MdEnable = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  con_ex_pipe_if.slave    bus
);
  state_t state_reg, state_next;

  logic [WordSize-1:0] a_mux, b_mux, a_reg, b_reg;
  logic [5:0]          mode_reg;
  logic                md_reg;
  logic                branch_taken_reg;
  logic [4:0]          rdn_reg;
  logic [WordSize-1:0] pc_reg, branch_addr_reg, rs2d_reg;

  logic                accept, in_md, md_start, md_busy, md_done;
  logic [WordSize-1:0] alu_result, md_result;

  always_comb begin
    case (bus.a_sel)
      A_PC:    a_mux = bus.pc_in;
      A_ZERO:  a_mux = '0;
      default: a_mux = bus.rs1d;
    endcase
    case (bus.b_sel)
      B_RS2:   b_mux = bus.rs2d_in;
      B_IMM:   b_mux = bus.imm;
      B_FOUR:  b_mux = WordSize'(4);
      default: b_mux = '0;
    endcase
  end

  assign in_md        = MdEnable && is_md(bus.alu_mode);
  assign bus.in_ready = !rst && ((state_reg == EMPTY) || ((state_reg == FULL) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign md_start     = accept && in_md;

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_next = in_md ? BUSY : FULL;
        BUSY: begin
          if (md_done)       state_next = FULL;
          else if (!md_busy) state_next = EMPTY;  // unit idle without a result
        end
        FULL: begin
          if (accept)             state_next = in_md ? BUSY : FULL;
          else if (bus.out_ready) state_next = EMPTY;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= EMPTY;
      a_reg            <= '0;
      b_reg            <= '0;
      mode_reg         <= '0;
      md_reg           <= 1'b0;
      branch_taken_reg <= 1'b0;
      rdn_reg          <= '0;
      pc_reg           <= '0;
      branch_addr_reg  <= '0;
      rs2d_reg         <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg            <= a_mux;
        b_reg            <= b_mux;
        mode_reg         <= bus.alu_mode;
        md_reg           <= in_md;
        branch_taken_reg <= bus.branch_taken_in;
        rdn_reg          <= bus.rdn_in;
        pc_reg           <= bus.pc_in;
        branch_addr_reg  <= bus.branch_addr_in;
        rs2d_reg         <= bus.rs2d_in;
      end
    end
  end

  Alu #(.WordSize(WordSize)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .mode   (mode_reg),
    .result (alu_result)
  );

  generate
    if (MdEnable) begin : g_md
      muldiv_iter #(.WordSize(WordSize)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .abort  (bus.flush),
        .start  (md_start),
        .op     (md_op_t'(bus.alu_mode[1:0])),
        .a      (a_mux),
        .b      (b_mux),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  assign bus.out_valid    = (state_reg == FULL);
  assign bus.alu_out      = (state_reg == FULL) ? (md_reg ? md_result : alu_result) : '0;
  assign bus.branch_taken = branch_taken_reg;
  assign bus.rdn          = rdn_reg;
  assign bus.pc           = pc_reg;
  assign bus.branch_addr  = branch_addr_reg;
  assign bus.rs2d         = rs2d_reg;
endmodule

// File: tb/tb_con_ex_pipe.sv
// Directed bench for con_ex_pipe (WordSize=32, MdEnable=1).
module tb_con_ex_pipe;
  import con_ex_pipe_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  con_ex_pipe_if #(.WordSize(32)) bus ();

  con_ex_pipe #(.WordSize(32), .MdEnable(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] mode, input logic [1:0] asel, input logic [1:0] bsel,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] immv,
                          input logic [31:0] pcv, input logic [4:0] rdv);
    bus.alu_mode = mode;
    bus.a_sel    = asel;
    bus.b_sel    = bsel;
    bus.rs1d     = rs1;
    bus.rs2d_in  = rs2;
    bus.imm      = immv;
    bus.pc_in    = pcv;
    bus.rdn_in   = rdv;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_md(input string tag, input logic [5:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int rdy;
    drive_op(mode, A_RS1, B_RS2, a, b, 32'h0, 32'h80, 5'd10);
    bus.out_ready = 1'b1;
    check({tag, ".ready_idle"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    rdy = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy++;
      tick();
      lat++;
    end
    check({tag, ".latency"}, lat, 32);
    check({tag, ".ready_busy"}, rdy, 0);
    check({tag, ".result"}, bus.alu_out, exp);
    $display("txn %s a=0x%08h b=0x%08h result=0x%08h cycles=%0d", tag, a, b, bus.alu_out, lat);
    tick();
    check({tag, ".drained"}, bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.branch_taken_in = 1'b0;
    bus.a_sel = 2'd0; bus.b_sel = 2'd0; bus.imm = '0; bus.pc_in = '0; bus.rs1d = '0;
    bus.rs2d_in = '0; bus.branch_addr_in = '0; bus.rdn_in = '0; bus.alu_mode = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.alu_out", bus.alu_out, 0);
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.rdn", bus.rdn, 0);
    check("rst.pc", bus.pc, 0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", bus.in_ready, 1);

    // ADD 5+7 with sidebands, then back-to-back pc+4
    drive_op(ALU_ADD, A_RS1, B_IMM, 32'd5, 32'h55, 32'd7, 32'h100, 5'd3);
    bus.branch_taken_in = 1'b1;
    bus.branch_addr_in  = 32'h1234;
    bus.out_ready       = 1'b1;
    tick();
    check("add.valid", bus.out_valid, 1);
    check("add.result", bus.alu_out, 32'd12);
    check("add.rdn", bus.rdn, 5'd3);
    check("add.pc", bus.pc, 32'h100);
    check("add.rs2d", bus.rs2d, 32'h55);
    check("add.baddr", bus.branch_addr, 32'h1234);
    check("add.btaken", bus.branch_taken, 1);
    check("add.ready_full", bus.in_ready, 1);
    $display("txn add result=0x%08h rdn=%0d", bus.alu_out, bus.rdn);
    drive_op(ALU_ADD, A_PC, B_FOUR, 32'd0, 32'd0, 32'd0, 32'h200, 5'd4);
    bus.branch_taken_in = 1'b0;
    tick();
    check("b2b.valid", bus.out_valid, 1);
    check("b2b.result", bus.alu_out, 32'h204);
    check("b2b.rdn", bus.rdn, 5'd4);
    check("b2b.btaken", bus.branch_taken, 0);
    $display("txn pc4 result=0x%08h rdn=%0d", bus.alu_out, bus.rdn);
    drive_op(ALU_SUB, A_RS1, B_RS2, 32'd20, 32'd8, 32'd0, 32'h0, 5'd6);
    tick();
    check("sub.result", bus.alu_out, 32'd12);
    $display("txn sub result=0x%08h", bus.alu_out);
    bus.in_valid = 1'b0;
    tick();
    check("idle.valid", bus.out_valid, 0);
    check("idle.alu_out", bus.alu_out, 0);

    // multiply / divide
    run_md("mul", MD_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    run_md("divu", MD_DIVU, 32'd100, 32'd7, 32'd14);
    run_md("remu", MD_REMU, 32'd100, 32'd7, 32'd2);
    run_md("divu0", MD_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_md("remu0", MD_REMU, 32'd9, 32'd0, 32'd9);

    // stall: result held while out_ready=0
    drive_op(ALU_ADD, A_RS1, B_IMM, 32'd1, 32'd0, 32'd2, 32'h0, 5'd7);
    bus.out_ready = 1'b0;
    tick();
    drive_op(ALU_ADD, A_RS1, B_IMM, 32'd10, 32'd0, 32'd20, 32'h0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      check("stall.ready", bus.in_ready, 0);
      check("stall.result", bus.alu_out, 32'd3);
      check("stall.rdn", bus.rdn, 5'd7);
      check("stall.valid", bus.out_valid, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("swap.ready", bus.in_ready, 1);
    tick();
    check("swap.valid", bus.out_valid, 1);
    check("swap.result", bus.alu_out, 32'd30);
    check("swap.rdn", bus.rdn, 5'd9);
    $display("txn stall_swap result=0x%08h rdn=%0d", bus.alu_out, bus.rdn);
    bus.in_valid = 1'b0;
    tick();
    check("swap.drained", bus.out_valid, 0);

    // flush in the 10th BUSY cycle
    drive_op(MD_MUL, A_RS1, B_RS2, 32'd3, 32'd4, 32'd0, 32'h0, 5'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    check("flush.busy_ready", bus.in_ready, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush.valid", bus.out_valid, 0);
    check("flush.ready", bus.in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    check("flush.no_result", cnt, 0);
    $display("txn flush_busy valid_cycles=%0d", cnt);

    // flush wins over accept
    drive_op(ALU_ADD, A_RS1, B_IMM, 32'd1, 32'd0, 32'd1, 32'h0, 5'd2);
    bus.flush = 1'b1;
    #1;
    check("flushacc.ready", bus.in_ready, 1);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flushacc.valid", bus.out_valid, 0);
    tick();
    check("flushacc.valid2", bus.out_valid, 0);
    $display("txn flush_accept valid=%0d", bus.out_valid);

    // reset mid-BUSY
    drive_op(MD_DIVU, A_RS1, B_RS2, 32'd1000, 32'd3, 32'd0, 32'h40, 5'd5);
    bus.branch_taken_in = 1'b1;
    bus.branch_addr_in  = 32'h88;
    tick();
    bus.in_valid = 1'b0;
    check("rstbusy.rdn_latched", bus.rdn, 5'd5);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("rstbusy.valid", bus.out_valid, 0);
    check("rstbusy.alu_out", bus.alu_out, 0);
    check("rstbusy.rdn", bus.rdn, 0);
    check("rstbusy.pc", bus.pc, 0);
    check("rstbusy.baddr", bus.branch_addr, 0);
    check("rstbusy.btaken", bus.branch_taken, 0);
    check("rstbusy.ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstbusy.ready_after", bus.in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    check("rstbusy.no_result", cnt, 0);
    $display("txn rst_busy valid_cycles=%0d", cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
